// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and types for the interrupt pending/arbitration front end.
//   IRQ_N       number of request lines (matches the downstream 16-to-4 encoder)
//   IRQ_IDX_W   width of a line index / round-robin pointer
//   irq_state_t arbiter FSM state
package irq_pkg;

    localparam int unsigned IRQ_N     = 16;
    localparam int unsigned IRQ_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } irq_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req      in   IRQ_N      candidate request vector
//   ptr      in   IRQ_IDX_W  search start position (highest priority)
//   pick     out  IRQ_N      one-hot first set bit of req at or after ptr (wrapping); 0 if none
//   pick_idx out  IRQ_IDX_W  index of pick (0 when req is empty)
module rr_pick
    import irq_pkg::*;
(
    input  logic [IRQ_N-1:0]     req,
    input  logic [IRQ_IDX_W-1:0] ptr,
    output logic [IRQ_N-1:0]     pick,
    output logic [IRQ_IDX_W-1:0] pick_idx
);

    logic                 found;
    logic [IRQ_IDX_W-1:0] pos;

    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_idx = '0;
        pos      = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            // Index arithmetic wraps naturally at IRQ_IDX_W bits.
            pos = ptr + IRQ_IDX_W'(i);
            if (!found && req[pos]) begin
                found     = 1'b1;
                pick[pos] = 1'b1;
                pick_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: rising-edge interrupt latch with masked round-robin one-hot grant.
//   clk      in   1      clock, all state on rising edge
//   rst      in   1      synchronous active-high reset
//   irq_in   in   N      synchronous request lines; each 0->1 transition is one event
//   mask     in   N      1 = line masked (still latches pending, never granted)
//   ack      in   1      consumer acknowledge, honoured only while valid
//   grant    out  N      registered one-hot grant, zero when valid is low
//   valid    out  1      grant holds a live request
//   pending  out  N      pending event register
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N     = IRQ_N,
    parameter int unsigned IDX_W = IRQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     mask,
    input  logic             ack,
    output logic [N-1:0]     grant,
    output logic             valid,
    output logic [N-1:0]     pending
);

    irq_state_t state_q, state_d;

    logic [N-1:0]     irq_q;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     cand;
    logic [N-1:0]     pick;
    logic [IDX_W-1:0] pick_idx;

    assign rise = irq_in & ~irq_q;
    // Candidates come from registered pending only, so a new edge needs one more
    // cycle before it can be granted and no input reaches the outputs combinationally.
    assign cand = pending_q & ~mask;

    rr_pick u_rr_pick (
        .req      (cand),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        clr         = '0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (cand != '0) begin
                    grant_d     = pick;
                    grant_idx_d = pick_idx;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    clr     = grant_q;
                    ptr_d   = grant_idx_q + IDX_W'(1);
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
        // Rise is OR-ed in after the clear so a coincident new edge is never lost.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            irq_q       <= '0;
            pending_q   <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_in;
            pending_q   <= pending_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant   = grant_q;
    assign valid   = (state_q == GRANT);
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
module tb_irq_pending_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq_in;
    logic [15:0] mask;
    logic        ack;
    logic [15:0] grant;
    logic        valid;
    logic [15:0] pending;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    irq_pending_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .mask    (mask),
        .ack     (ack),
        .grant   (grant),
        .valid   (valid),
        .pending (pending)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_in = '0; mask = '0; ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({grant, valid, pending} !== 33'd0) begin
            tests_failed++;
            $display("FAIL reset_state: grant=%h valid=%b pending=%h, want 0/0/0",
                     grant, valid, pending);
        end
    endtask

    task automatic test_single_event();
        do_reset();
        irq_in = 16'h0020;
        tick();
        irq_in = '0;
        tests_run++;
        if (pending !== 16'h0020 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pending: pending=%h valid=%b, want 0020/0", pending, valid);
        end
        tick();
        tests_run++;
        if (grant !== 16'h0020 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: grant=%h valid=%b, want 0020/1", grant, valid);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tests_run++;
        if (grant !== 16'h0 || valid !== 1'b0 || pending !== 16'h0) begin
            tests_failed++;
            $display("FAIL single_ack: grant=%h valid=%b pending=%h, want 0/0/0",
                     grant, valid, pending);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_a [3] = '{16'h0004, 16'h0200, 16'h4000};
        logic [15:0] exp_b [2] = '{16'h0004, 16'h0200};
        do_reset();
        irq_in = 16'h4204;
        tick();
        irq_in = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (grant !== exp_a[i] || valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_first[%0d]: grant=%h valid=%b, want %h/1",
                         i, grant, valid, exp_a[i]);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        // ptr is now 15: search wraps 15,0,1,2 -> line 2 first.
        irq_in = 16'h0204;
        tick();
        irq_in = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (grant !== exp_b[i] || valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_wrap[%0d]: grant=%h valid=%b, want %h/1",
                         i, grant, valid, exp_b[i]);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
    endtask

    task automatic test_mask();
        do_reset();
        mask = 16'h0008;
        irq_in = 16'h0008;
        tick();
        irq_in = '0;
        tick();
        tests_run++;
        if (pending !== 16'h0008 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_hold: pending=%h valid=%b, want 0008/0", pending, valid);
        end
        mask = '0;
        tick();
        tests_run++;
        if (grant !== 16'h0008 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mask_release: grant=%h valid=%b, want 0008/1", grant, valid);
        end
        mask = 16'h0008;
        tick();
        tests_run++;
        if (grant !== 16'h0008 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mask_no_revoke: grant=%h valid=%b, want 0008/1", grant, valid);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        mask = '0;
    endtask

    task automatic test_ack_and_edge();
        do_reset();
        irq_in = 16'h0100;
        tick();
        tick();
        tests_run++;
        if (grant !== 16'h0100 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL collide_setup: grant=%h valid=%b, want 0100/1", grant, valid);
        end
        irq_in = '0;
        tick();
        irq_in = 16'h0100;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tests_run++;
        if (pending !== 16'h0100 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL collide_rise_wins: pending=%h valid=%b, want 0100/0", pending, valid);
        end
        tick();
        tests_run++;
        if (grant !== 16'h0100 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL collide_reissue: grant=%h valid=%b, want 0100/1", grant, valid);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        irq_in = '0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        irq_in = 16'h0003;
        tick();
        irq_in = 16'h0001;
        tick();
        tests_run++;
        if (grant !== 16'h0001 || valid !== 1'b1 || pending !== 16'h0003) begin
            tests_failed++;
            $display("FAIL midrst_setup: grant=%h valid=%b pending=%h, want 0001/1/0003",
                     grant, valid, pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (grant !== 16'h0 || valid !== 1'b0 || pending !== 16'h0) begin
            tests_failed++;
            $display("FAIL midrst_clear: grant=%h valid=%b pending=%h, want 0/0/0",
                     grant, valid, pending);
        end
        tick();
        tests_run++;
        if (pending !== 16'h0001 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_event: pending=%h valid=%b, want 0001/0", pending, valid);
        end
        tick();
        tests_run++;
        if (grant !== 16'h0001 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_regrant: grant=%h valid=%b, want 0001/1", grant, valid);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        // Line still held high: no further edge, so nothing more is granted.
        tests_run++;
        if (valid !== 1'b0 || pending !== 16'h0) begin
            tests_failed++;
            $display("FAIL midrst_single: valid=%b pending=%h, want 0/0000", valid, pending);
        end
        irq_in = '0;
    endtask

    task automatic test_random_invariants();
        logic [15:0] prev_grant;
        logic        prev_valid;
        logic        prev_ack;
        int          bad_onehot = 0;
        int          bad_valid  = 0;
        int          bad_hold   = 0;
        do_reset();
        prev_grant = grant;
        prev_valid = valid;
        prev_ack   = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            irq_in = 16'($urandom);
            mask   = 16'($urandom) & 16'($urandom);
            ack    = ($urandom_range(0, 3) == 0);
            prev_ack = ack;
            tick();
            tests_run++;
            if ((grant & (grant - 16'd1)) !== 16'd0) begin
                tests_failed++;
                if (bad_onehot++ < 5)
                    $display("FAIL rand_onehot: cycle %0d grant=%h, want zero or one-hot",
                             c, grant);
            end
            tests_run++;
            if (valid !== (grant != 16'd0)) begin
                tests_failed++;
                if (bad_valid++ < 5)
                    $display("FAIL rand_valid: cycle %0d valid=%b grant=%h, want valid==|grant",
                             c, valid, grant);
            end
            if (prev_valid && !prev_ack) begin
                tests_run++;
                if (grant !== prev_grant || valid !== 1'b1) begin
                    tests_failed++;
                    if (bad_hold++ < 5)
                        $display("FAIL rand_hold: cycle %0d grant=%h valid=%b, want %h/1",
                                 c, grant, valid, prev_grant);
                end
            end
            if (prev_valid && prev_ack) begin
                tests_run++;
                if (valid !== 1'b0) begin
                    tests_failed++;
                    if (bad_hold++ < 5)
                        $display("FAIL rand_release: cycle %0d valid=%b, want 0", c, valid);
                end
            end
            prev_grant = grant;
            prev_valid = valid;
        end
        ack = 1'b0;
        irq_in = '0;
        mask = '0;
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mask = '0; ack = 1'b0;
        #1;
        test_reset();
        test_single_event();
        test_round_robin();
        test_mask();
        test_ack_and_edge();
        test_reset_mid_grant();
        test_random_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
